// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command byte transmitter driving open-drain pull-low enables
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       timeout,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_REQ,
      S_SEND,
      S_ACK,
      S_WAIT_IDLE
   } state_t;

   state_t             state;
   logic [2:0]         clk_sync;
   logic [2:0]         data_sync;
   logic               fall;
   logic               clk_s;
   logic               data_s;
   logic [7:0]         tx_byte;
   logic               parity_bit;
   logic [3:0]         bitcnt;
   logic [INH_W-1:0]   inh_cnt;
   logic [TO_W-1:0]    wdog;
   logic               watched;
   logic               wdog_expire;
   logic               ack_seen;

   // Three-flop synchronisers for the asynchronous pad inputs; reset to the idle-high level
   // so that leaving reset never looks like a clock falling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync  <= 3'b111;
         data_sync <= 3'b111;
      end else begin
         clk_sync  <= {clk_sync[1:0], ps2_clk};
         data_sync <= {data_sync[1:0], ps2_data};
      end
   end

   assign fall   = clk_sync[2] & ~clk_sync[1];
   assign clk_s  = clk_sync[1];
   assign data_s = data_sync[1];

   assign busy = (state != S_IDLE);

   // The watchdog only runs while the device is expected to be clocking; an edge always
   // beats expiry in the same cycle.
   always_comb begin
      watched     = (state == S_REQ) || (state == S_SEND) || (state == S_ACK);
      wdog_expire = watched && !fall && (wdog == TO_LAST);
   end

   // Watchdog: counts cycles since the last device clock edge (or since the request).
   always_ff @(posedge clk) begin
      if (rst || !watched || fall) begin
         wdog <= '0;
      end else begin
         wdog <= wdog + 1'b1;
      end
   end

   // Transfer FSM: inhibit, request-to-send, bit shifting on device clock edges, ack, release.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         done        <= 1'b0;
         ack_err     <= 1'b0;
         timeout     <= 1'b0;
         tx_ready    <= 1'b1;
         tx_byte     <= 8'h00;
         parity_bit  <= 1'b0;
         bitcnt      <= 4'd0;
         inh_cnt     <= '0;
         ack_seen    <= 1'b0;
      end else begin
         done    <= 1'b0;
         ack_err <= 1'b0;
         timeout <= 1'b0;
         if (wdog_expire) begin
            // Device went silent: let go of the bus and report the abort instead of done.
            state       <= S_IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            timeout     <= 1'b1;
            tx_ready    <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b0;
                  tx_ready    <= 1'b1;
                  if (tx_valid && tx_ready) begin
                     tx_byte    <= tx_data;
                     parity_bit <= ~^tx_data;
                     bitcnt     <= 4'd0;
                     inh_cnt    <= '0;
                     ps2_clk_oe <= 1'b1;
                     tx_ready   <= 1'b0;
                     state      <= S_INHIBIT;
                  end
               end
               S_INHIBIT: begin
                  if (inh_cnt == INH_LAST) begin
                     // Release the clock and present the start bit in the same cycle.
                     ps2_clk_oe  <= 1'b0;
                     ps2_data_oe <= 1'b1;
                     state       <= S_REQ;
                  end else begin
                     inh_cnt <= inh_cnt + 1'b1;
                  end
               end
               S_REQ: begin
                  if (fall) begin
                     ps2_data_oe <= ~tx_byte[0];
                     bitcnt      <= 4'd1;
                     state       <= S_SEND;
                  end
               end
               S_SEND: begin
                  if (fall) begin
                     bitcnt <= bitcnt + 4'd1;
                     if (bitcnt <= 4'd7) begin
                        ps2_data_oe <= ~tx_byte[bitcnt[2:0]];
                     end else if (bitcnt == 4'd8) begin
                        ps2_data_oe <= ~parity_bit;
                     end else begin
                        // Stop bit is a released line; the device owns data for the ack.
                        ps2_data_oe <= 1'b0;
                        state       <= S_ACK;
                     end
                  end
               end
               S_ACK: begin
                  if (fall) begin
                     bitcnt   <= bitcnt + 4'd1;
                     ack_seen <= data_s;
                     state    <= S_WAIT_IDLE;
                  end
               end
               S_WAIT_IDLE: begin
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b0;
                  if (clk_s && data_s) begin
                     // tx_ready comes back one cycle after done, from the IDLE branch.
                     done    <= 1'b1;
                     ack_err <= ack_seen;
                     state   <= S_IDLE;
                  end
               end
               default: begin
                  state       <= S_IDLE;
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b0;
                  tx_ready    <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a behavioural PS/2 device model
module tb_ps2_host_tx;

   localparam int INH  = 8;
   localparam int TO   = 200;
   localparam int HALF = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, busy, done, ack_err, timeout, ps2_clk_oe, ps2_data_oe;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;
   logic       line_clk, line_data;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int to_cnt   = 0;
   int acc_cnt  = 0;

   // Wired-AND open-drain bus: either side pulling low wins.
   assign line_clk  = ~(ps2_clk_oe | dev_clk_low);
   assign line_data = ~(ps2_data_oe | dev_data_low);

   always #5 clk = ~clk;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (line_clk),
      .ps2_data   (line_data),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .done       (done),
      .ack_err    (ack_err),
      .timeout    (timeout),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe)
   );

   // Pulse and handshake counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (done)               done_cnt <= done_cnt + 1;
      if (timeout)            to_cnt   <= to_cnt + 1;
      if (tx_valid && tx_ready) acc_cnt <= acc_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic logic odd_parity(input logic [7:0] b);
      return ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
   endfunction

   // mode 0: full frame, 1: device never clocks, 2: reset at bit 4
   task automatic send_byte(input logic [7:0] b, input bit do_ack, input int mode, input bit hold);
      logic q[$];
      logic exp_bits[$];
      int   n;
      int   d0;
      int   t0;
      bit   ok;
      exp_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
      exp_bits.push_back(odd_parity(b));
      exp_bits.push_back(1'b1);
      d0 = done_cnt;
      t0 = to_cnt;

      n = 0;
      while (!tx_ready && n < 100) begin
         tick();
         n++;
      end
      check("ready_before_send", 32'(tx_ready), 32'd1);
      tx_data  = b;
      tx_valid = 1'b1;
      tick();
      if (!hold) tx_valid = 1'b0;
      check("clk_oe_after_accept", 32'(ps2_clk_oe), 32'd1);
      check("busy_after_accept", 32'(busy), 32'd1);

      n  = 1;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (!ps2_clk_oe) begin
            ok = 1'b1;
            break;
         end
         n++;
      end
      check("inhibit_ended", 32'(ok), 32'd1);
      check("inhibit_len", 32'(n), 32'(INH));
      check("start_bit_driven", 32'(ps2_data_oe), 32'd1);

      if (mode == 1) begin
         n  = 0;
         ok = 1'b0;
         for (int i = 0; i < 400; i++) begin
            tick();
            n++;
            if (timeout) begin
               ok = 1'b1;
               break;
            end
         end
         check("timeout_seen", 32'(ok), 32'd1);
         check("timeout_cycle", 32'(n), 32'(TO));
         check("timeout_clk_oe", 32'(ps2_clk_oe), 32'd0);
         check("timeout_data_oe", 32'(ps2_data_oe), 32'd0);
         check("timeout_ready", 32'(tx_ready), 32'd1);
         tick();
         check("timeout_width", 32'(timeout), 32'd0);
         check("timeout_count", 32'(to_cnt - t0), 32'd1);
         check("no_done_on_timeout", 32'(done_cnt - d0), 32'd0);
         return;
      end

      q.push_back(line_data);
      for (int f = 1; f <= 11; f++) begin
         if (f == 11) begin
            wait_cycles(HALF / 2);
            if (do_ack) dev_data_low = 1'b1;
            wait_cycles(HALF / 2);
         end else begin
            wait_cycles(HALF);
         end
         dev_clk_low = 1'b1;
         if (mode == 2 && f == 5) begin
            wait_cycles(10);
            rst = 1'b1;
            tick();
            rst = 1'b0;
            check("rst_mid_clk_oe", 32'(ps2_clk_oe), 32'd0);
            check("rst_mid_data_oe", 32'(ps2_data_oe), 32'd0);
            check("rst_mid_busy", 32'(busy), 32'd0);
            check("rst_mid_done", 32'(done), 32'd0);
            check("rst_mid_ready", 32'(tx_ready), 32'd1);
            dev_clk_low = 1'b0;
            wait_cycles(5);
            check("rst_no_done", 32'(done_cnt - d0), 32'd0);
            check("rst_no_timeout", 32'(to_cnt - t0), 32'd0);
            return;
         end
         wait_cycles(HALF);
         dev_clk_low = 1'b0;
         if (f <= 10) q.push_back(line_data);
      end
      dev_data_low = 1'b0;

      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      check("done_seen", 32'(ok), 32'd1);
      check("ack_err", 32'(ack_err), 32'(!do_ack));
      check("done_clk_oe", 32'(ps2_clk_oe), 32'd0);
      check("done_data_oe", 32'(ps2_data_oe), 32'd0);
      check("ready_during_done", 32'(tx_ready), 32'd0);
      tick();
      check("done_width", 32'(done), 32'd0);
      check("ready_after_done", 32'(tx_ready), 32'd1);
      check("done_count", 32'(done_cnt - d0), 32'd1);
      check("no_timeout", 32'(to_cnt - t0), 32'd0);
      check("frame_len", 32'(q.size()), 32'd11);
      for (int i = 0; i < 11 && i < q.size(); i++) begin
         check($sformatf("frame_bit%0d_byte%02h", i, b), 32'(q[i]), 32'(exp_bits[i]));
      end
   endtask

   initial begin
      int a0;
      rst = 1'b1;
      wait_cycles(3);
      check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
      check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ack_err", 32'(ack_err), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(tx_ready), 32'd1);
      rst = 1'b0;
      tick();

      send_byte(8'hED, 1'b1, 0, 1'b0);
      send_byte(8'h00, 1'b0, 0, 1'b0);
      send_byte(8'hFF, 1'b1, 0, 1'b0);
      send_byte(8'hF4, 1'b1, 1, 1'b0);

      a0 = acc_cnt;
      send_byte(8'h55, 1'b1, 0, 1'b1);
      check("held_valid_single_accept", 32'(acc_cnt - a0), 32'd1);
      send_byte(8'h3C, 1'b1, 0, 1'b0);
      check("second_accept_after_done", 32'(acc_cnt - a0), 32'd2);

      send_byte(8'hA5, 1'b1, 2, 1'b0);
      send_byte(8'h5A, 1'b1, 0, 1'b0);

      for (int k = 0; k < 4; k++) begin
         send_byte(8'($urandom), 1'($urandom), 0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter that sends one command byte (LED set, typematic, reset, etc.) from the host to the keyboard. It drives the shared open-drain ps2_clk/ps2_data lines through active-high pull-low enables and sits alongside the PS/2 keyboard receiver in the keyboard top level. It owns the bus only while `busy` is high; the receiver ignores traffic during that time.

## Interface
- INHIBIT_CYCLES, 5000: `clk` cycles ps2_clk is held low before the request (≥100 µs at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum `clk` cycles allowed between device clock falling edges, or while waiting for the first one.
- clk  in  1  system clock; sole clock domain.
- rst  in  1  synchronous, active-high reset.
- ps2_clk  in  1  PS/2 clock line as read from the pad (asynchronous).
- ps2_data  in  1  PS/2 data line as read from the pad (asynchronous).
- tx_data  in  8  command byte; sampled when `tx_valid & tx_ready`.
- tx_valid  in  1  request to send `tx_data`.
- tx_ready  out  1  high only in IDLE; a byte is accepted on the `tx_valid & tx_ready` cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a frame completes, whether or not it was acknowledged.
- ack_err  out  1  valid with `done`; 1 if the device did not pull data low in the ack slot.
- timeout  out  1  one-cycle pulse when a transfer is aborted by the timeout.
- ps2_clk_oe  out  1  1 = pull ps2_clk low; 0 = release.
- ps2_data_oe  out  1  1 = pull ps2_data low; 0 = release.

## Operation
- Input sync: each of ps2_clk and ps2_data passes through 3 flops. A falling edge `fall` is detected when sync[2]=1 and sync[1]=0. All protocol decisions use the synced values.
- Frame: start(0), d0..d7 LSB first, odd parity (`~^tx_data`), stop(1), then the device-driven ack(0).
- Driving a bit: `ps2_data_oe = ~bit`. A 1 is never driven high.
- States and transitions:
  - IDLE: both oe=0. On accept, latch the byte and parity, clear the counters, go to INHIBIT.
  - INHIBIT: ps2_clk_oe=1. After INHIBIT_CYCLES cycles, assert ps2_data_oe=1 (start bit) and go to REQ.
  - REQ: ps2_clk_oe=0, ps2_data_oe=1. The bit counter bitcnt=0.
  - SEND: on each `fall`, increment bitcnt and present the next bit.
    - fall 1..8 present d0..d7.
    - fall 9 presents parity.
    - fall 10 presents stop (ps2_data_oe=0); go to ACK.
  - ACK: on `fall` 11, sample synced data. ack_err = synced data. Go to WAIT_IDLE.
  - WAIT_IDLE: both oe=0. When synced clk=1 and synced data=1, pulse `done` with `ack_err` valid and go to IDLE.
- Timeout: the watchdog counts cycles in REQ, SEND and ACK and clears on every `fall`. On reaching TIMEOUT_CYCLES:
  - release both lines;
  - pulse `timeout` (and not `done`);
  - go to IDLE.
- tx_valid outside IDLE is ignored; there is no queuing.
- Reset mid-transfer: the next cycle is IDLE with both lines released. No `done` or `timeout` pulse is generated.

## Timing
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, done=0, ack_err=0, timeout=0, busy=0, tx_ready=1.
- The accept cycle is followed by ps2_clk_oe=1 on the next cycle.
- ps2_clk_oe stays high for exactly INHIBIT_CYCLES cycles. ps2_data_oe rises in the same cycle ps2_clk_oe falls.
- Data updates 1 cycle after `fall` is detected, which is 3–4 `clk` cycles after the pad edge. This is well inside the device's low half-period.
- `done` asserts 1 cycle after both synced lines are observed high in WAIT_IDLE. tx_ready returns on the following cycle.
- `fall` and timeout expiry in the same cycle: the edge wins and the watchdog clears.

## Test plan
Parameters: INHIBIT_CYCLES=8, TIMEOUT_CYCLES=200. The device model runs a 40-cycle PS/2 clock and samples data on rising edges.

- Send 0xED → ps2_clk held low for 8 cycles. Model captures 0, 1,0,1,1,0,1,1,1, parity 1, stop 1. Model acks → `done`=1, ack_err=0, lines released.
- Send 0x00 → parity bit 1, stop 1. Model withholds the ack → `done`=1, ack_err=1.
- Send 0xFF → parity bit 1, ps2_data_oe=0 for all data bits.
- Model never clocks after the request → `timeout` pulses 200 cycles into REQ, both oe=0, tx_ready=1. `done` never pulses.
- tx_valid held high through a whole 0x55 transfer → exactly one frame sent. A second byte is accepted only after `done`.
- rst asserted at bit 4 of a 0xA5 transfer → next cycle both oe=0, busy=0, no `done`. A subsequent 0x5A send completes with ack_err=0.
